// File: rtl/lane_ir_reg_pkg.sv
// Shared encodings for the lane-assembled instruction register: fun_sel codes and fill states
// (the fill states are also decoded by the control unit).
package lane_ir_reg_pkg;

    typedef enum logic [1:0] {
        FS_CLEAR = 2'b00,
        FS_LOAD  = 2'b01,
        FS_DEC   = 2'b10,
        FS_INC   = 2'b11
    } fun_sel_e;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        PARTIAL = 2'b01,
        FULL    = 2'b10
    } fill_e;

    function automatic int ptr_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/lane_ir_reg_if.sv
// Bus bundle between the memory-side driver (master) and lane_ir_reg (slave).
interface lane_ir_reg_if #(
    parameter int LANE_W = 8,
    parameter int LANES  = 2
);
    import lane_ir_reg_pkg::*;

    localparam int PTR_W = ptr_width(LANES);
    localparam int WIDTH = LANES * LANE_W;

    logic              en;
    logic [1:0]        fun_sel;
    logic              auto_lane;
    logic [PTR_W-1:0]  lane_sel;
    logic [LANE_W-1:0] data_in;
    logic [WIDTH-1:0]  data_out;
    logic [PTR_W-1:0]  lane_ptr;
    logic              full;
    logic              wrap;

    modport master (
        output en, fun_sel, auto_lane, lane_sel, data_in,
        input  data_out, lane_ptr, full, wrap
    );

    modport slave (
        input  en, fun_sel, auto_lane, lane_sel, data_in,
        output data_out, lane_ptr, full, wrap
    );

endinterface

// File: rtl/lane_ir_ptr.sv
// Modulo-LANES auto-load pointer plus written-lane mask and fill-state tracking.
//
//   state   | meaning
//   EMPTY   | no lane written since last clear/reset
//   PARTIAL | at least one, but not every, lane written
//   FULL    | every lane written; full=1
module lane_ir_ptr
    import lane_ir_reg_pkg::*;
#(
    parameter  int LANES = 2,
    localparam int PTR_W = ptr_width(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic             wr,
    input  logic [PTR_W-1:0] wr_idx,
    output logic [PTR_W-1:0] ptr,
    output logic             full
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [LANES-1:0] mask_q, mask_d;
    fill_e            state_q, state_d;
    logic             wr_ok;

    // Explicit indices beyond the last lane (non-power-of-2 LANES) are dropped.
    assign wr_ok = wr && (int'(wr_idx) < LANES);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            mask_q  <= '0;
            state_q <= EMPTY;
        end else begin
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        mask_d  = mask_q;
        state_d = state_q;
        if (clr) begin
            ptr_d   = '0;
            mask_d  = '0;
            state_d = EMPTY;
        end else begin
            if (wr_ok) begin
                mask_d[wr_idx] = 1'b1;
            end
            if (adv) begin
                ptr_d = (int'(ptr_q) == LANES - 1) ? '0 : ptr_q + PTR_W'(1);
            end
            case (state_q)
                EMPTY:   if (wr_ok) state_d = (&mask_d) ? FULL : PARTIAL;
                PARTIAL: if (wr_ok && (&mask_d)) state_d = FULL;
                FULL:    state_d = FULL;
                default: state_d = EMPTY;
            endcase
        end
    end

    assign ptr  = ptr_q;
    assign full = (state_q == FULL);

endmodule

// File: rtl/lane_ir_reg.sv
// Instruction register assembled one LANE_W lane per cycle, with clear and whole-word inc/dec.
// Build option: define LANE_IR_SATURATE_EN to make inc/dec saturate instead of wrapping.
module lane_ir_reg
    import lane_ir_reg_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int LANES  = 2
) (
    input  logic          clk,
    input  logic          rst,
    lane_ir_reg_if.slave  bus
);

    localparam int PTR_W = ptr_width(LANES);
    localparam int WIDTH = LANES * LANE_W;

    fun_sel_e         fs;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] tgt;
    logic             full;
    logic [WIDTH-1:0] data_q, data_d;
    logic             wrap_q, wrap_d;
    logic             clr_op, load_op;

    assign fs      = fun_sel_e'(bus.fun_sel);
    assign tgt     = bus.auto_lane ? ptr : bus.lane_sel;
    assign clr_op  = bus.en && (fs == FS_CLEAR);
    assign load_op = bus.en && (fs == FS_LOAD);

    lane_ir_ptr #(
        .LANES (LANES)
    ) u_ptr (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_op),
        .adv    (load_op && bus.auto_lane),
        .wr     (load_op),
        .wr_idx (tgt),
        .ptr    (ptr),
        .full   (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            data_q <= data_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        data_d = data_q;
        wrap_d = 1'b0;
        if (bus.en) begin
            case (fs)
                FS_CLEAR: data_d = '0;
                FS_LOAD: begin
                    // An out-of-range tgt matches no lane, so nothing is written.
                    for (int l = 0; l < LANES; l++) begin
                        if (l == int'(tgt)) data_d[l*LANE_W +: LANE_W] = bus.data_in;
                    end
                end
                FS_DEC: begin
                    wrap_d = (data_q == '0);
`ifdef LANE_IR_SATURATE_EN
                    data_d = wrap_d ? data_q : data_q - WIDTH'(1);
`else
                    data_d = data_q - WIDTH'(1);
`endif
                end
                FS_INC: begin
                    wrap_d = (data_q == '1);
`ifdef LANE_IR_SATURATE_EN
                    data_d = wrap_d ? data_q : data_q + WIDTH'(1);
`else
                    data_d = data_q + WIDTH'(1);
`endif
                end
                default: data_d = data_q;
            endcase
        end
    end

    assign bus.data_out = data_q;
    assign bus.lane_ptr = ptr;
    assign bus.full     = full;
    assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_lane_ir_reg.sv
// Bench for lane_ir_reg: a 2-lane and a 3-lane instance driven with identical stimulus,
// directed scenarios plus randomized ops checked against a lane-level arithmetic model.
module tb_lane_ir_reg;

`ifdef LANE_IR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        longint val;
        int     ptr;
        int     mask;
        bit     wrap;
    } model_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;
    model_t ma = '{0, 0, 0, 1'b0};
    model_t mb = '{0, 0, 0, 1'b0};

    always #5 clk = ~clk;

    lane_ir_reg_if #(.LANE_W(8), .LANES(2)) bus_a ();
    lane_ir_reg_if #(.LANE_W(8), .LANES(3)) bus_b ();

    lane_ir_reg #(.LANE_W(8), .LANES(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    lane_ir_reg #(.LANE_W(8), .LANES(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    function automatic model_t mstep(input model_t s, input int lanes, input int lw, input bit r,
                                     input bit e, input int fs, input bit au, input int sel,
                                     input int din);
        model_t n = s;
        longint topv = (longint'(1) << (lanes * lw)) - 1;
        longint lm   = (longint'(1) << lw) - 1;
        int     tgt;
        n.wrap = 1'b0;
        if (r) begin
            n = '{0, 0, 0, 1'b0};
        end else if (e) begin
            case (fs)
                0: begin n.val = 0; n.mask = 0; n.ptr = 0; end
                1: begin
                    tgt = au ? s.ptr : sel;
                    if (tgt < lanes) begin
                        n.val  = (s.val & ~(lm << (tgt * lw))) | ((longint'(din) & lm) << (tgt * lw));
                        n.mask = s.mask | (1 << tgt);
                    end
                    if (au) n.ptr = (s.ptr + 1) % lanes;
                end
                2: begin
                    if (s.val == 0) begin n.wrap = 1'b1; n.val = SAT ? 0 : topv; end
                    else n.val = s.val - 1;
                end
                default: begin
                    if (s.val == topv) begin n.wrap = 1'b1; n.val = SAT ? topv : 0; end
                    else n.val = s.val + 1;
                end
            endcase
        end
        return n;
    endfunction

    task automatic drive(input bit r, input bit e, input int fs, input bit au, input int sel,
                         input int din);
        rst             = r;
        bus_a.en        = e;
        bus_a.fun_sel   = 2'(fs);
        bus_a.auto_lane = au;
        bus_a.lane_sel  = 1'(sel);
        bus_a.data_in   = 8'(din);
        bus_b.en        = e;
        bus_b.fun_sel   = 2'(fs);
        bus_b.auto_lane = au;
        bus_b.lane_sel  = 2'(sel);
        bus_b.data_in   = 8'(din);
        @(posedge clk);
        #1;
        ma = mstep(ma, 2, 8, r, e, fs, au, sel & 1, din & 255);
        mb = mstep(mb, 3, 8, r, e, fs, au, sel & 3, din & 255);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0);
        vectors++;
        if ({bus_a.data_out, bus_a.lane_ptr, bus_a.full, bus_a.wrap} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset {data,ptr,full,wrap}: got %h want %h",
                     {bus_a.data_out, bus_a.lane_ptr, bus_a.full, bus_a.wrap}, 19'h0);
        end
        drive(0, 0, 1, 1, 0, 'hAA);
        vectors++;
        if ({bus_a.data_out, bus_a.lane_ptr, bus_a.full} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL en0_hold {data,ptr,full}: got %h want %h",
                     {bus_a.data_out, bus_a.lane_ptr, bus_a.full}, 18'h0);
        end
    endtask

    task automatic test_auto_load();
        drive(0, 1, 1, 1, 0, 'h05);
        vectors++;
        if ({bus_a.data_out, bus_a.lane_ptr, bus_a.full} !== {16'h0005, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL auto_load0 {data,ptr,full}: got %h want %h",
                     {bus_a.data_out, bus_a.lane_ptr, bus_a.full}, {16'h0005, 1'b1, 1'b0});
        end
        drive(0, 1, 1, 1, 0, 'hAA);
        vectors++;
        if ({bus_a.data_out, bus_a.lane_ptr, bus_a.full} !== {16'hAA05, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL auto_load1 {data,ptr,full}: got %h want %h",
                     {bus_a.data_out, bus_a.lane_ptr, bus_a.full}, {16'hAA05, 1'b0, 1'b1});
        end
    endtask

    task automatic test_explicit_load();
        drive(0, 1, 1, 0, 1, 'h3C);
        vectors++;
        if ({bus_a.data_out, bus_a.lane_ptr, bus_a.full} !== {16'h3C05, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL explicit_load {data,ptr,full}: got %h want %h",
                     {bus_a.data_out, bus_a.lane_ptr, bus_a.full}, {16'h3C05, 1'b0, 1'b1});
        end
        drive(0, 1, 0, 0, 0, 0);
        vectors++;
        if ({bus_a.data_out, bus_a.lane_ptr, bus_a.full} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clear {data,ptr,full}: got %h want %h",
                     {bus_a.data_out, bus_a.lane_ptr, bus_a.full}, 18'h0);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_d;
        logic        exp_w;
        drive(0, 1, 1, 0, 0, 'hFF);
        drive(0, 1, 1, 0, 1, 'hFF);
        vectors++;
        if (bus_a.data_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL fill_ones data: got %h want %h", bus_a.data_out, 16'hFFFF);
        end
        drive(0, 1, 3, 0, 0, 0);
        exp_d = SAT ? 16'hFFFF : 16'h0000;
        vectors++;
        if ({bus_a.data_out, bus_a.wrap} !== {exp_d, 1'b1}) begin
            errors++;
            $display("FAIL inc_ovf {data,wrap}: got %h want %h", {bus_a.data_out, bus_a.wrap}, {exp_d, 1'b1});
        end
        drive(0, 0, 3, 0, 0, 0);
        vectors++;
        if ({bus_a.data_out, bus_a.wrap} !== {exp_d, 1'b0}) begin
            errors++;
            $display("FAIL wrap_pulse_end {data,wrap}: got %h want %h", {bus_a.data_out, bus_a.wrap}, {exp_d, 1'b0});
        end
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 2, 0, 0, 0);
        exp_d = SAT ? 16'h0000 : 16'hFFFF;
        vectors++;
        if ({bus_a.data_out, bus_a.wrap} !== {exp_d, 1'b1}) begin
            errors++;
            $display("FAIL dec_udf {data,wrap}: got %h want %h", {bus_a.data_out, bus_a.wrap}, {exp_d, 1'b1});
        end
        drive(0, 1, 3, 0, 0, 0);
        exp_d = SAT ? 16'h0001 : 16'h0000;
        exp_w = !SAT;
        vectors++;
        if ({bus_a.data_out, bus_a.wrap} !== {exp_d, exp_w}) begin
            errors++;
            $display("FAIL inc_after_dec {data,wrap}: got %h want %h", {bus_a.data_out, bus_a.wrap}, {exp_d, exp_w});
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 'h11);
        vectors++;
        if ({bus_a.data_out, bus_a.lane_ptr} !== {16'h0011, 1'b1}) begin
            errors++;
            $display("FAIL mid_load {data,ptr}: got %h want %h", {bus_a.data_out, bus_a.lane_ptr}, {16'h0011, 1'b1});
        end
        drive(1, 1, 3, 0, 0, 0);
        vectors++;
        if ({bus_a.data_out, bus_a.lane_ptr, bus_a.full, bus_a.wrap} !== 19'h0) begin
            errors++;
            $display("FAIL mid_reset {data,ptr,full,wrap}: got %h want %h",
                     {bus_a.data_out, bus_a.lane_ptr, bus_a.full, bus_a.wrap}, 19'h0);
        end
        drive(0, 1, 1, 1, 0, 'h22);
        vectors++;
        if ({bus_a.data_out, bus_a.lane_ptr, bus_a.full} !== {16'h0022, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_load {data,ptr,full}: got %h want %h",
                     {bus_a.data_out, bus_a.lane_ptr, bus_a.full}, {16'h0022, 1'b1, 1'b0});
        end
    endtask

    task automatic test_lanes3();
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 'h01);
        drive(0, 1, 1, 1, 0, 'h02);
        vectors++;
        if ({bus_b.data_out, bus_b.lane_ptr, bus_b.full} !== {24'h000201, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL l3_partial {data,ptr,full}: got %h want %h",
                     {bus_b.data_out, bus_b.lane_ptr, bus_b.full}, {24'h000201, 2'd2, 1'b0});
        end
        drive(0, 1, 1, 1, 0, 'h03);
        vectors++;
        if ({bus_b.data_out, bus_b.lane_ptr, bus_b.full} !== {24'h030201, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL l3_full {data,ptr,full}: got %h want %h",
                     {bus_b.data_out, bus_b.lane_ptr, bus_b.full}, {24'h030201, 2'd0, 1'b1});
        end
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 3, 'h77);
        vectors++;
        if ({bus_b.data_out, bus_b.lane_ptr, bus_b.full} !== {24'h000000, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL l3_bad_sel {data,ptr,full}: got %h want %h",
                     {bus_b.data_out, bus_b.lane_ptr, bus_b.full}, 27'h0);
        end
    endtask

    task automatic test_random();
        bit r, e, au;
        int fs, sel, din;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 49) == 0);
            e   = ($urandom_range(0, 7) != 0);
            fs  = $urandom_range(0, 3);
            au  = $urandom_range(0, 1);
            sel = $urandom_range(0, 3);
            din = ($urandom_range(0, 2) == 0) ? 'hFF : $urandom_range(0, 255);
            drive(r, e, fs, au, sel, din);
            vectors++;
            if ({bus_a.data_out, bus_a.lane_ptr, bus_a.full, bus_a.wrap} !==
                {16'(ma.val), 1'(ma.ptr), ma.mask == 3, ma.wrap}) begin
                errors++;
                $display("FAIL rand_a[%0d] {data,ptr,full,wrap}: got %h want %h", i,
                         {bus_a.data_out, bus_a.lane_ptr, bus_a.full, bus_a.wrap},
                         {16'(ma.val), 1'(ma.ptr), ma.mask == 3, ma.wrap});
            end
            vectors++;
            if ({bus_b.data_out, bus_b.lane_ptr, bus_b.full, bus_b.wrap} !==
                {24'(mb.val), 2'(mb.ptr), mb.mask == 7, mb.wrap}) begin
                errors++;
                $display("FAIL rand_b[%0d] {data,ptr,full,wrap}: got %h want %h", i,
                         {bus_b.data_out, bus_b.lane_ptr, bus_b.full, bus_b.wrap},
                         {24'(mb.val), 2'(mb.ptr), mb.mask == 7, mb.wrap});
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus_a.en        = 1'b0;
        bus_a.fun_sel   = 2'b00;
        bus_a.auto_lane = 1'b0;
        bus_a.lane_sel  = '0;
        bus_a.data_in   = '0;
        bus_b.en        = 1'b0;
        bus_b.fun_sel   = 2'b00;
        bus_b.auto_lane = 1'b0;
        bus_b.lane_sel  = '0;
        bus_b.data_in   = '0;
        test_reset();
        test_auto_load();
        test_explicit_load();
        test_wrap();
        test_reset_mid();
        test_lanes3();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
